// File: rtl/mau_pkg.sv
// Shared types and constants for the ktc32 load/store front-end.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    localparam int unsigned MEM_BYTES = 32768;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mau_align.sv
// Lane steering: sub-word load extraction/extension and sub-word store merge.
module mau_align import mau_pkg::*; (
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  size_e       i_size,
    input  logic        i_signed,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_load  = i_word;
        o_store = i_wdata;
        case (i_size)
            SZ_B: begin
                o_load  = {{24{i_signed & w_byte[7]}}, w_byte};
                o_store = i_word;
                o_store[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_H: begin
                o_load  = {{16{i_signed & w_half[15]}}, w_half};
                o_store = i_word;
                o_store[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: one request per transaction, sub-word stores by read-modify-write,
// bad requests answered with an error and no memory access.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = mau_pkg::MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wd,
    input  logic [31:0] i_mem_data
);
    import mau_pkg::*;

    state_e      r_state, w_next;
    logic        r_we, r_signed, r_err;
    size_e       r_size;
    logic [31:0] r_addr, r_wdata, r_merge, r_rdata;

    size_e       w_req_size;
    logic        w_req_err;
    logic [31:0] w_load, w_store;

    assign w_req_size = size_e'(i_req_size);

    always_comb begin
        w_req_err = 1'b0;
        case (w_req_size)
            SZ_H:    w_req_err = i_req_addr[0];
            SZ_W:    w_req_err = |i_req_addr[1:0];
            SZ_BAD:  w_req_err = 1'b1;
            default: ;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range
        if ({1'b0, word_align(i_req_addr)} + 33'd3 >= 33'(MEM_BYTES))
            w_req_err = 1'b1;
    end

    mau_align u_align (
        .i_word   (i_mem_data),
        .i_wdata  (r_wdata),
        .i_offset (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_store  (w_store)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    if (w_req_err)                         w_next = RESP;
                    else if (i_req_we && w_req_size == SZ_W) w_next = WRITE;
                    else                                    w_next = READ;
                end
            end
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    if (i_resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= SZ_B;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we     <= i_req_we;
                        r_size   <= w_req_size;
                        r_signed <= i_req_signed;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                        r_merge  <= i_req_wdata;
                        r_rdata  <= '0;
                        r_err    <= w_req_err;
                    end
                end
                READ: begin
                    if (r_we) r_merge <= w_store;
                    else      r_rdata <= w_load;
                end
                default: ;
            endcase
        end
    end

    // Memory strobes come from state alone, so reset kills a pending write at once
    assign o_mem_we     = (r_state == WRITE);
    assign o_mem_addr   = word_align(r_addr);
    assign o_mem_wd     = o_mem_we ? r_merge : '0;

    assign o_req_ready  = (r_state == IDLE);
    assign o_resp_valid = (r_state == RESP);
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

endmodule
